// File: rtl/cpu7_excp_ctl_pkg.sv
// cpu7_excp_ctl_pkg: CSR addresses and sequencer state encodings shared by the
// exception/return sequencer and its CSR port multiplexer.
package cpu7_excp_ctl_pkg;

    // CSR addresses used by the sequencer (LoongArch numbering)
    localparam logic [13:0] LSOC1K_CSR_CRMD  = 14'h000;
    localparam logic [13:0] LSOC1K_CSR_PRMD  = 14'h001;
    localparam logic [13:0] LSOC1K_CSR_EPC   = 14'h006;
    localparam logic [13:0] LSOC1K_CSR_EBASE = 14'h00c;

    // Width of the PIE/PPLV field carried from PRMD back into CRMD
    localparam int PRMD_FIELD_W = 3;

    typedef enum logic [2:0] {
        EXCP_ST_IDLE      = 3'd0,
        EXCP_ST_EXC_ERA   = 3'd1,
        EXCP_ST_EXC_ENTRY = 3'd2,
        EXCP_ST_RET_PRMD  = 3'd3,
        EXCP_ST_RET_CRMD  = 3'd4,
        EXCP_ST_RET_ERA   = 3'd5
    } excp_state_e;

endpackage

// File: rtl/cpu7_excp_csr_mux.sv
// cpu7_excp_csr_mux: selects who owns the CSR port -- the pipeline while the
// sequencer is idle, the sequencer otherwise. Pipeline writes are never
// forwarded while the sequencer owns the port.
module cpu7_excp_csr_mux #(
    parameter int GRLEN   = 32,
    parameter int CSR_BIT = 14
) (
    input  logic               sel_pipe,
    input  logic [CSR_BIT-1:0] pipe_raddr,
    input  logic [CSR_BIT-1:0] pipe_waddr,
    input  logic [GRLEN-1:0]   pipe_wdata,
    input  logic               pipe_wen,
    input  logic [CSR_BIT-1:0] seq_raddr,
    input  logic [CSR_BIT-1:0] seq_waddr,
    input  logic [GRLEN-1:0]   seq_wdata,
    input  logic               seq_wen,
    output logic [CSR_BIT-1:0] csr_raddr,
    output logic [CSR_BIT-1:0] csr_waddr,
    output logic [GRLEN-1:0]   csr_wdata,
    output logic               csr_wen
);

    // Two-way select of the complete CSR port
    always_comb begin
        csr_raddr = seq_raddr;
        csr_waddr = seq_waddr;
        csr_wdata = seq_wdata;
        csr_wen   = seq_wen;
        if (sel_pipe) begin
            csr_raddr = pipe_raddr;
            csr_waddr = pipe_waddr;
            csr_wdata = pipe_wdata;
            csr_wen   = pipe_wen;
        end
    end

endmodule

// File: rtl/cpu7_excp_ctl.sv
// cpu7_excp_ctl: exception / ertn sequencer. Saves ERA and fetches EENTRY on
// an exception, restores CRMD from PRMD and fetches ERA on ertn, then issues a
// single fetch redirect. While idle the pipeline's CSR accesses pass through.
module cpu7_excp_ctl
    import cpu7_excp_ctl_pkg::*;
#(
    parameter int GRLEN   = 32,
    parameter int CSR_BIT = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_excp_req,
    input  logic [GRLEN-1:0]   ex_excp_pc,
    input  logic               ex_ertn_req,
    input  logic [CSR_BIT-1:0] pipe_csr_raddr,
    input  logic [CSR_BIT-1:0] pipe_csr_waddr,
    input  logic [GRLEN-1:0]   pipe_csr_wdata,
    input  logic               pipe_csr_wen,
    output logic [CSR_BIT-1:0] csr_raddr,
    input  logic [GRLEN-1:0]   csr_rdata,
    output logic [CSR_BIT-1:0] csr_waddr,
    output logic [GRLEN-1:0]   csr_wdata,
    output logic               csr_wen,
    output logic               csr_excp,
    output logic               excp_flush,
    output logic               excp_busy,
    output logic               redirect_valid,
    output logic [GRLEN-1:0]   redirect_pc
);

    excp_state_e             state_q, state_d;
    logic [GRLEN-1:0]        pc_q, pc_d;
    logic [PRMD_FIELD_W-1:0] prmd_q, prmd_d;

    logic [CSR_BIT-1:0] seq_raddr;
    logic [CSR_BIT-1:0] seq_waddr;
    logic [GRLEN-1:0]   seq_wdata;
    logic               seq_wen;
    logic               sel_pipe;

    // State, faulting PC and PIE/PPLV latches; async reset to idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EXCP_ST_IDLE;
            pc_q    <= '0;
            prmd_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            prmd_q  <= prmd_d;
        end
    end

    // Next-state logic and sequencer drive of the CSR port and redirect
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        prmd_d         = prmd_q;
        seq_raddr      = '0;
        seq_waddr      = '0;
        seq_wdata      = '0;
        seq_wen        = 1'b0;
        csr_excp       = 1'b0;
        excp_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state_q)
            EXCP_ST_IDLE: begin
                // Exception has priority; a simultaneous ertn is dropped
                if (!reset && ex_excp_req) begin
                    pc_d       = ex_excp_pc;
                    excp_flush = 1'b1;
                    state_d    = EXCP_ST_EXC_ERA;
                end else if (!reset && ex_ertn_req) begin
                    excp_flush = 1'b1;
                    state_d    = EXCP_ST_RET_PRMD;
                end
            end
            EXCP_ST_EXC_ERA: begin
                seq_waddr = CSR_BIT'(LSOC1K_CSR_EPC);
                seq_wdata = pc_q;
                seq_wen   = 1'b1;
                csr_excp  = 1'b1;
                state_d   = EXCP_ST_EXC_ENTRY;
            end
            EXCP_ST_EXC_ENTRY: begin
                seq_raddr      = CSR_BIT'(LSOC1K_CSR_EBASE);
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
                state_d        = EXCP_ST_IDLE;
            end
            EXCP_ST_RET_PRMD: begin
                seq_raddr = CSR_BIT'(LSOC1K_CSR_PRMD);
                prmd_d    = csr_rdata[PRMD_FIELD_W-1:0];
                state_d   = EXCP_ST_RET_CRMD;
            end
            EXCP_ST_RET_CRMD: begin
                seq_waddr = CSR_BIT'(LSOC1K_CSR_CRMD);
                seq_wdata = {{(GRLEN-PRMD_FIELD_W){1'b0}}, prmd_q};
                seq_wen   = 1'b1;
                state_d   = EXCP_ST_RET_ERA;
            end
            EXCP_ST_RET_ERA: begin
                seq_raddr      = CSR_BIT'(LSOC1K_CSR_EPC);
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
                state_d        = EXCP_ST_IDLE;
            end
            default: begin
                state_d = EXCP_ST_IDLE;
            end
        endcase
    end

    assign sel_pipe  = (state_q == EXCP_ST_IDLE);
    assign excp_busy = !sel_pipe;

    cpu7_excp_csr_mux #(
        .GRLEN   (GRLEN),
        .CSR_BIT (CSR_BIT)
    ) u_csr_mux (
        .sel_pipe   (sel_pipe),
        .pipe_raddr (pipe_csr_raddr),
        .pipe_waddr (pipe_csr_waddr),
        .pipe_wdata (pipe_csr_wdata),
        .pipe_wen   (pipe_csr_wen),
        .seq_raddr  (seq_raddr),
        .seq_waddr  (seq_waddr),
        .seq_wdata  (seq_wdata),
        .seq_wen    (seq_wen),
        .csr_raddr  (csr_raddr),
        .csr_waddr  (csr_waddr),
        .csr_wdata  (csr_wdata),
        .csr_wen    (csr_wen)
    );

endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// tb_cpu7_excp_ctl: directed plus randomized bench for the exception/ertn
// sequencer. A small CSR-file array answers reads; a queue of expected
// per-cycle CSR-port activity is built from the latency rules on each accept.
module tb_cpu7_excp_ctl;

    localparam logic [13:0] A_CRMD  = 14'h000;
    localparam logic [13:0] A_PRMD  = 14'h001;
    localparam logic [13:0] A_EPC   = 14'h006;
    localparam logic [13:0] A_EBASE = 14'h00c;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_excp_req;
    logic [31:0] ex_excp_pc;
    logic        ex_ertn_req;
    logic [13:0] pipe_csr_raddr;
    logic [13:0] pipe_csr_waddr;
    logic [31:0] pipe_csr_wdata;
    logic        pipe_csr_wen;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic        csr_excp;
    logic        excp_flush;
    logic        excp_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] csr_mem [0:15];

    typedef struct {
        logic [13:0] raddr;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic        wen;
        logic        excp;
        logic        rv;
        logic [31:0] rpc;
    } cyc_t;

    cyc_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign csr_rdata = (csr_raddr < 14'd16) ? csr_mem[csr_raddr[3:0]] : {18'h0, csr_raddr};

    cpu7_excp_ctl #(.GRLEN(32), .CSR_BIT(14)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_excp_req    (ex_excp_req),
        .ex_excp_pc     (ex_excp_pc),
        .ex_ertn_req    (ex_ertn_req),
        .pipe_csr_raddr (pipe_csr_raddr),
        .pipe_csr_waddr (pipe_csr_waddr),
        .pipe_csr_wdata (pipe_csr_wdata),
        .pipe_csr_wen   (pipe_csr_wen),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_wen        (csr_wen),
        .csr_excp       (csr_excp),
        .excp_flush     (excp_flush),
        .excp_busy      (excp_busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input logic [13:0] ra, input logic [13:0] wa,
                                input logic [31:0] wd, input logic we, input logic ex,
                                input logic rv, input logic [31:0] rpc);
        cyc_t c;
        c.raddr = ra; c.waddr = wa; c.wdata = wd; c.wen = we;
        c.excp = ex; c.rv = rv; c.rpc = rpc;
        return c;
    endfunction

    // One cycle: inputs already applied just after the posedge
    task automatic step();
        cyc_t e;
        logic busy_e, flush_e;
        if (reset) q.delete();
        if (q.size() != 0) begin
            e = q[0];
            busy_e = 1'b1;
            flush_e = 1'b0;
        end else begin
            e = mk(pipe_csr_raddr, pipe_csr_waddr, pipe_csr_wdata, pipe_csr_wen, 1'b0, 1'b0, 32'h0);
            busy_e = 1'b0;
            flush_e = !reset && (ex_excp_req || ex_ertn_req);
        end
        @(negedge clk);
        chk("csr_raddr", 64'(csr_raddr), 64'(e.raddr));
        chk("csr_waddr", 64'(csr_waddr), 64'(e.waddr));
        chk("csr_wen", 64'(csr_wen), 64'(e.wen));
        if (e.wen) chk("csr_wdata", 64'(csr_wdata), 64'(e.wdata));
        chk("csr_excp", 64'(csr_excp), 64'(e.excp));
        chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
        if (e.rv) chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
        chk("excp_busy", 64'(excp_busy), 64'(busy_e));
        chk("excp_flush", 64'(excp_flush), 64'(flush_e));
        if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (!reset) begin
            if (ex_excp_req) begin
                q.push_back(mk(14'h0, A_EPC, ex_excp_pc, 1'b1, 1'b1, 1'b0, 32'h0));
                q.push_back(mk(A_EBASE, 14'h0, 32'h0, 1'b0, 1'b0, 1'b1, csr_mem[A_EBASE[3:0]]));
            end else if (ex_ertn_req) begin
                q.push_back(mk(A_PRMD, 14'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
                q.push_back(mk(14'h0, A_CRMD, {29'b0, csr_mem[A_PRMD[3:0]][2:0]},
                               1'b1, 1'b0, 1'b0, 32'h0));
                q.push_back(mk(A_EPC, 14'h0, 32'h0, 1'b0, 1'b0, 1'b1, csr_mem[A_EPC[3:0]]));
            end
        end
        @(posedge clk);
        #1;
        ex_excp_req = 1'b0;
        ex_ertn_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) csr_mem[i] = 32'h1000_0000 + 32'(i);
        reset = 1'b0;
        ex_excp_req = 1'b0; ex_ertn_req = 1'b0; ex_excp_pc = 32'h0;
        pipe_csr_raddr = 14'h0; pipe_csr_waddr = 14'h0;
        pipe_csr_wdata = 32'h0; pipe_csr_wen = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset state: requests are masked while reset is high
        ex_excp_req = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Pipeline csrwr in IDLE is forwarded the same cycle
        pipe_csr_wen = 1'b1; pipe_csr_waddr = 14'h030; pipe_csr_wdata = 32'h1234_5678;
        pipe_csr_raddr = 14'h005;
        step();
        pipe_csr_wen = 1'b0;

        // Exception from IDLE, with a pipeline write attempted while busy
        csr_mem[A_EBASE[3:0]] = 32'h1c00_8000;
        ex_excp_pc = 32'h1c00_0010;
        ex_excp_req = 1'b1;
        step();
        pipe_csr_wen = 1'b1;
        step();
        step();
        pipe_csr_wen = 1'b0;
        step();

        // ertn with PRMD=7, ERA=0x1c000014
        csr_mem[A_PRMD[3:0]] = 32'h0000_0007;
        csr_mem[A_EPC[3:0]]  = 32'h1c00_0014;
        ex_ertn_req = 1'b1;
        step();
        pipe_csr_wen = 1'b1;
        step();
        step();
        step();
        pipe_csr_wen = 1'b0;
        step();

        // Simultaneous requests: exception wins
        ex_excp_pc = 32'h1c00_0020;
        ex_excp_req = 1'b1; ex_ertn_req = 1'b1;
        step();
        step();
        step();
        step();

        // Reset while in EXC_ENTRY, then a fresh exception
        ex_excp_pc = 32'h1c00_0030;
        ex_excp_req = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        ex_excp_pc = 32'h1c00_0040;
        ex_excp_req = 1'b1;
        step();
        step();
        step();

        // Back-to-back: exception, then ertn in the first idle cycle
        ex_excp_pc = 32'h1c00_0050;
        ex_excp_req = 1'b1;
        step();
        step();
        step();
        ex_ertn_req = 1'b1;
        step();
        step();
        step();
        step();
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 59) == 0) reset = 1'b1;
            if (q.size() == 0) begin
                csr_mem[A_PRMD[3:0]]  = $urandom;
                csr_mem[A_EPC[3:0]]   = $urandom;
                csr_mem[A_EBASE[3:0]] = $urandom;
            end
            pipe_csr_raddr = 14'($urandom);
            pipe_csr_waddr = 14'($urandom);
            pipe_csr_wdata = $urandom;
            pipe_csr_wen   = 1'($urandom);
            ex_excp_pc     = $urandom;
            ex_excp_req    = ($urandom_range(0, 3) == 0);
            ex_ertn_req    = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
